// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared constants and state encoding for the parking keypad.
package parking_pkg;

    localparam int DIGIT_MAX       = 9;
    localparam int TIMEOUT_DEFAULT = 1000;
    localparam int NUM_DIGITS      = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        COLLECT = 3'b001,
        FULL    = 3'b010,
        READY   = 3'b011
    } state_t;

endpackage

// File: rtl/entry_timer.sv
// rtl/entry_timer.sv - saturating inactivity counter for a password entry in progress.
module entry_timer
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] TERM = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Counter only advances while an entry is open; it parks at the terminal value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (restart || !run) begin
            count <= '0;
        end else if (count != TERM) begin
            count <= count + 1'b1;
        end
    end

    assign expired = run && (count == TERM);

endmodule

// File: rtl/password_entry.sv
// rtl/password_entry.sv - keypad collector that commits a 4-digit password for the gate controller.
module password_entry
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CODE_WIDTH     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [CODE_WIDTH-1:0] key_code,
    input  logic                  key_enter,
    input  logic                  key_clear,
    output logic [CODE_WIDTH-1:0] P4,
    output logic [CODE_WIDTH-1:0] P3,
    output logic [CODE_WIDTH-1:0] P2,
    output logic [CODE_WIDTH-1:0] P1,
    output logic                  pass_ready,
    output logic [2:0]            digit_count,
    output logic                  entry_error,
    output logic                  entry_timeout
);

    typedef logic [NUM_DIGITS-1:0][CODE_WIDTH-1:0] digits_t;

    state_t     state, state_nxt;
    digits_t    digits_q, digits_nxt;
    digits_t    commit_q, commit_nxt;
    logic       ready_q, ready_nxt;
    logic [2:0] count_q, count_nxt;
    logic       err_q, err_nxt;
    logic       to_q, to_nxt;
    logic       accepted, invalid, run, restart, expired;
    logic [1:0] slot;

    assign accepted = key_valid && (key_code <= CODE_WIDTH'(DIGIT_MAX));
    assign invalid  = key_valid && !accepted;
    assign run      = (state == COLLECT) || (state == FULL);
    // Slot 3 is the P4 position, so the first digit lands in the top nibble.
    assign slot     = 2'd3 - count_q[1:0];

    entry_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .restart(restart),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            digits_q <= '0;
            commit_q <= '0;
            ready_q  <= 1'b0;
            count_q  <= 3'd0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            digits_q <= digits_nxt;
            commit_q <= commit_nxt;
            ready_q  <= ready_nxt;
            count_q  <= count_nxt;
            err_q    <= err_nxt;
            to_q     <= to_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        digits_nxt = digits_q;
        commit_nxt = commit_q;
        ready_nxt  = ready_q;
        count_nxt  = count_q;
        err_nxt    = 1'b0;
        to_nxt     = 1'b0;
        restart    = 1'b0;

        if (key_clear) begin
            state_nxt  = IDLE;
            digits_nxt = '0;
            commit_nxt = '0;
            ready_nxt  = 1'b0;
            count_nxt  = 3'd0;
        end else if (key_enter) begin
            case (state)
                FULL: begin
                    commit_nxt = digits_q;
                    ready_nxt  = 1'b1;
                    state_nxt  = READY;
                end
                IDLE, COLLECT: begin
                    err_nxt    = 1'b1;
                    digits_nxt = '0;
                    count_nxt  = 3'd0;
                    state_nxt  = IDLE;
                end
                default: ;
            endcase
        end else if (accepted) begin
            restart = 1'b1;
            case (state)
                IDLE, READY: begin
                    digits_nxt    = '0;
                    digits_nxt[3] = key_code;
                    commit_nxt    = '0;
                    ready_nxt     = 1'b0;
                    count_nxt     = 3'd1;
                    state_nxt     = COLLECT;
                end
                COLLECT: begin
                    digits_nxt[slot] = key_code;
                    count_nxt        = count_q + 3'd1;
                    if (count_q == 3'd3) begin
                        state_nxt = FULL;
                    end
                end
                default: err_nxt = 1'b1;
            endcase
        end else begin
            err_nxt = invalid;
            // Accepted keys and enter already won above; only idleness reaches here.
            if (expired) begin
                to_nxt     = 1'b1;
                digits_nxt = '0;
                count_nxt  = 3'd0;
                state_nxt  = IDLE;
            end
        end
    end

    assign P4            = commit_q[3];
    assign P3            = commit_q[2];
    assign P2            = commit_q[1];
    assign P1            = commit_q[0];
    assign pass_ready    = ready_q;
    assign digit_count   = count_q;
    assign entry_error   = err_q;
    assign entry_timeout = to_q;

endmodule

// File: doc/password_entry.md
PASSWORD_ENTRY -- requirements
Module: password_entry

Interface
REQ-001 SHALL take parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed between keys before the entry is abandoned.
REQ-002 SHALL take parameter CODE_WIDTH, default 4: bits per digit; fixed at 4 for this system.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_valid, input, 1 bit: one-cycle strobe marking key_code as a new key press.
REQ-006 SHALL have port key_code, input, 4 bits: pressed digit; only 0-9 are legal.
REQ-007 SHALL have port key_enter, input, 1 bit: one-cycle enter-key strobe.
REQ-008 SHALL have port key_clear, input, 1 bit: one-cycle clear-key strobe.
REQ-009 SHALL have ports P4, P3, P2, P1, output, 4 bits each: committed password digits, P4 = first digit entered; these feed the gate controller.
REQ-010 SHALL have port pass_ready, output, 1 bit: high while P4..P1 hold a committed 4-digit entry.
REQ-011 SHALL have port digit_count, output, 3 bits: digits collected so far, 0-4.
REQ-012 SHALL have port entry_error, output, 1 bit: one-cycle pulse on any rejected action.
REQ-013 SHALL have port entry_timeout, output, 1 bit: one-cycle pulse when an entry is abandoned for inactivity.

Function
REQ-014 SHALL implement states IDLE, COLLECT, FULL and READY.
REQ-015 SHALL accept a key only when key_valid=1 and key_code<=9; key_code 10-15 SHALL be ignored, pulse entry_error and leave the timer unchanged.
REQ-016 SHALL handle an accepted key in IDLE by storing it as digit 1 (P4 slot), setting digit_count=1 and moving to COLLECT.
REQ-017 SHALL handle an accepted key in COLLECT by storing it in the next slot and incrementing digit_count; the 4th digit moves the FSM to FULL on the same edge.
REQ-018 SHALL, in FULL, ignore further digits, pulse entry_error and hold digit_count=4.
REQ-019 SHALL, on key_enter in FULL, copy the buffer to P4..P1 and raise pass_ready; both SHALL be visible the cycle after the enter edge (latency 1), and the FSM moves to READY.
REQ-020 SHALL, on key_enter in IDLE or COLLECT, pulse entry_error, clear the buffer, set digit_count=0 and return to IDLE.
REQ-021 SHALL, in READY, hold P4..P1 and pass_ready until key_clear or an accepted key arrives.
REQ-022 SHALL, on an accepted key in READY, zero P4..P1, drop pass_ready and start a new entry exactly as in REQ-016.
REQ-023 SHALL keep P4..P1 at 0 whenever pass_ready=0; partial entries are never exposed on these ports.
REQ-024 SHALL, on key_clear in any state, zero the buffer, P4..P1, digit_count and pass_ready, then go to IDLE.
REQ-025 SHALL give key_clear priority over key_enter, and key_enter priority over key_valid, when they arrive in the same cycle.
REQ-026 SHALL run an inactivity counter in COLLECT and FULL, reset to 0 on each accepted key.
REQ-027 SHALL, when the counter reaches TIMEOUT_CYCLES-1, pulse entry_timeout, clear the buffer and digit_count, and return to IDLE.
REQ-028 SHALL give an accepted key or key_enter in the terminal-count cycle priority over the timeout.
REQ-029 SHALL keep the timer inactive in IDLE and READY; READY never times out.
REQ-030 SHALL size the counter to $clog2(TIMEOUT_CYCLES) bits and SHALL saturate it, never wrapping.

Reset
REQ-031 SHALL, while reset=0, force asynchronously: state=IDLE, buffer=0, P4..P1=0, pass_ready=0, digit_count=0, entry_error=0, entry_timeout=0, timer=0.
REQ-032 SHALL, if reset is asserted mid-entry, discard the entry; the first accepted key after release is treated as digit 1.

Structure
REQ-033 SHALL take state encodings (3-bit, IDLE=3'b000), DIGIT_MAX=9 and the default TIMEOUT_CYCLES from shared package parking_pkg.
REQ-034 SHALL place the inactivity counter in sub-module entry_timer (ports: clk, reset, run, restart, expired).

Verification
REQ-035 SHALL check: keys 1,2,3,4 then enter -> one cycle after enter, P4..P1=1,2,3,4 and pass_ready=1; digit_count steps 1,2,3,4.
REQ-036 SHALL check: keys 1,2 then enter -> entry_error pulses once, digit_count=0, pass_ready stays 0, P4..P1=0.
REQ-037 SHALL check: TIMEOUT_CYCLES=8, key 5 then 8 idle cycles -> entry_timeout pulses once, FSM in IDLE; a key on cycle 8 instead -> no timeout, digit_count=2.
REQ-038 SHALL check: 5th key 7 while FULL -> entry_error pulses and digit_count stays 4; key_code=12 in COLLECT -> entry_error pulses and digit_count is unchanged.
REQ-039 SHALL check: READY holding 1,2,3,4, then key_clear and key_valid in the same cycle -> all outputs 0, FSM in IDLE, digit_count=0.
REQ-040 SHALL check: reset=0 asserted asynchronously mid-cycle after 3 digits -> all outputs 0 immediately; after release, keys 9,9,9,9 and enter -> P4..P1=9,9,9,9.
